// File: rtl/bias_loader.sv
// ---------------------------------------------------------------------------
// bias_loader
//
// Receives bias values from a 64-bit DMA stream and packs them into 128-bit
// bias-store words. Each stream beat carries two 32-bit biases. Two
// consecutive beats form one store word {odd_beat, even_beat}. A load of
// num_groups output groups consumes 4*num_groups beats and produces
// 2*num_groups store writes.
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst          synchronous, active-high reset
//   start        single-cycle load request, accepted only while idle
//   first_og     sampled at start; 1 = first output-group batch of a layer,
//                which clears the store write address before loading
//   num_groups   groups to load, sampled at start (legal 1..MAX_GROUPS)
//   s_tdata      stream beat: [31:0] = bias 2j, [63:32] = bias 2j+1
//   s_tvalid     stream beat valid
//   s_tlast      last beat of the DMA transfer
//   s_tready     stream accept, high only while loading
//   wr_en        bias-store write strobe (one cycle per word)
//   wr_data      packed store word, held between writes
//   wr_addr_rst  bias-store write-address clear (one cycle)
//   busy         load in progress
//   done         single-cycle load-complete pulse
//   err          sticky protocol/range error, cleared by the next start
// ---------------------------------------------------------------------------
module bias_loader #(
    parameter int MAX_GROUPS = 128,
    parameter int GW         = $clog2(MAX_GROUPS) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          first_og,
    input  logic [GW-1:0] num_groups,
    input  logic [63:0]   s_tdata,
    input  logic          s_tvalid,
    input  logic          s_tlast,
    output logic          s_tready,
    output logic          wr_en,
    output logic [127:0]  wr_data,
    output logic          wr_addr_rst,
    output logic          busy,
    output logic          done,
    output logic          err
);

    // Beat counter holds up to 4*MAX_GROUPS; GW already has one spare bit
    // above MAX_GROUPS, so GW+2 bits never wrap inside a legal load.
    localparam int CW = GW + 2;

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        LOAD,
        DONE
    } state_t;

    state_t        state;
    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] last_beat;
    logic [63:0]   even_q;

    logic beat_fire;
    logic at_last;
    logic bad_range;

    assign s_tready  = (state == LOAD);
    assign beat_fire = s_tvalid && s_tready;
    assign at_last   = (beat_cnt == last_beat);
    assign bad_range = (num_groups == '0) || (num_groups > GW'(MAX_GROUPS));

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            last_beat   <= '0;
            even_q      <= '0;
            wr_en       <= 1'b0;
            wr_data     <= '0;
            wr_addr_rst <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            // Strobes default low so each is a single-cycle pulse.
            wr_en       <= 1'b0;
            wr_addr_rst <= 1'b0;
            done        <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        busy      <= 1'b1;
                        beat_cnt  <= '0;
                        last_beat <= {num_groups, 2'b00} - CW'(1);
                        if (bad_range) begin
                            // Nothing to load: report and finish without
                            // touching the store.
                            err   <= 1'b1;
                            state <= DONE;
                        end else begin
                            err <= 1'b0;
                            if (first_og) begin
                                wr_addr_rst <= 1'b1;
                                state       <= CLR;
                            end else begin
                                // Later output-group batches append.
                                state <= LOAD;
                            end
                        end
                    end
                end

                CLR: begin
                    state <= LOAD;
                end

                LOAD: begin
                    if (beat_fire) begin
                        beat_cnt <= beat_cnt + CW'(1);
                        // Counter LSB is the beat parity within the load.
                        if (!beat_cnt[0]) begin
                            even_q <= s_tdata;
                        end else begin
                            wr_en   <= 1'b1;
                            wr_data <= {s_tdata, even_q};
                        end

                        if (at_last) begin
                            if (!s_tlast) begin
                                err <= 1'b1;
                            end
                            state <= DONE;
                        end else if (s_tlast) begin
                            // Transfer ended early; a dangling even beat is
                            // simply never written.
                            err   <= 1'b1;
                            state <= DONE;
                        end
                    end
                end

                DONE: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bias_loader.sv
// ---------------------------------------------------------------------------
// tb_bias_loader
//
// Directed sequence of bias loads with random bias data. The reference model
// is the stream itself: store word k of a load must equal
// {beat[2k+1], beat[2k]} of the beats sent, in order. A negedge monitor logs
// every write word and counts address-clear and done pulses.
// ---------------------------------------------------------------------------
module tb_bias_loader;

    localparam int MAX_GROUPS = 128;
    localparam int GW         = $clog2(MAX_GROUPS) + 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic          first_og;
    logic [GW-1:0] num_groups;
    logic [63:0]   s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic          wr_en;
    logic [127:0]  wr_data;
    logic          wr_addr_rst;
    logic          busy;
    logic          done;
    logic          err;

    bias_loader #(
        .MAX_GROUPS(MAX_GROUPS),
        .GW        (GW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_og   (first_og),
        .num_groups (num_groups),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_addr_rst(wr_addr_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Monitor: everything the DUT writes, plus pulse counts.
    logic [127:0] got[$];
    int           n_clr  = 0;
    int           n_done = 0;

    always @(negedge clk) begin
        if (wr_en)       got.push_back(wr_data);
        if (wr_addr_rst) n_clr++;
        if (done)        n_done++;
    end

    // Stream content of the current test, in transfer order.
    logic [63:0] beats[$];

    int base;
    int c0;
    int d0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic gen(input int n);
        for (int i = 0; i < n; i++) beats.push_back({$urandom, $urandom});
    endtask

    // Called at posedge+1; returns at posedge+1 right after the start edge.
    task automatic do_start(input logic fo, input int ng);
        first_og   = fo;
        num_groups = GW'(ng);
        start      = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
    endtask

    // Sends beats[off .. off+n-1]; s_tlast on relative index tlast_rel.
    // Returns at posedge+1 just after the last accepting edge.
    task automatic send(input string tag, input int off, input int n,
                        input int tlast_rel, input int gap_pct);
        int n_acc;
        n_acc = 0;
        for (int i = 0; i < n; i++) begin
            int  g;
            int  cyc;
            logic acc;
            g = 0;
            while (gap_pct > 0 && g < 4 && int'($urandom_range(99)) < gap_pct) begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
                @(posedge clk); #1;
                g++;
            end
            s_tdata  = beats[off + i];
            s_tvalid = 1'b1;
            s_tlast  = (i == tlast_rel);
            acc = 1'b0;
            cyc = 0;
            while (!acc && cyc < 200) begin
                @(negedge clk);
                acc = s_tready;
                @(posedge clk); #1;
                cyc++;
            end
            if (!acc) break;
            n_acc++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        chk({tag, "/beats_accepted"}, 128'(n_acc), 128'(n));
    endtask

    // Two cycles after the terminating edge: DONE (final write if any), then
    // IDLE with the done pulse.
    task automatic tail(input string tag, input logic exp_wr, input logic exp_err);
        @(negedge clk);
        chk({tag, "/final_wr_en"}, 128'(wr_en),    128'(exp_wr));
        chk({tag, "/ready_in_done"}, 128'(s_tready), 128'(0));
        chk({tag, "/busy_in_done"}, 128'(busy),     128'(1));
        chk({tag, "/done_early"},   128'(done),     128'(0));
        @(negedge clk);
        chk({tag, "/done_pulse"},   128'(done),     128'(1));
        chk({tag, "/busy_idle"},    128'(busy),     128'(0));
        chk({tag, "/no_extra_wr"},  128'(wr_en),    128'(0));
        chk({tag, "/err"},          128'(err),      128'(exp_err));
        @(posedge clk); #1;
    endtask

    task automatic check_words(input string tag, input int b, input int n_words);
        chk({tag, "/n_writes"}, 128'(got.size() - b), 128'(n_words));
        for (int k = 0; k < n_words && (b + k) < got.size(); k++)
            chk($sformatf("%s/word%0d", tag, k), got[b + k], {beats[2*k+1], beats[2*k]});
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // NOTE: inputs are driven with blocking assignments 1 time unit after
        // the clock edge so the DUT always samples settled values.
        rst        = 1'b1;
        start      = 1'b0;
        first_og   = 1'b0;
        num_groups = '0;
        s_tdata    = '0;
        s_tvalid   = 1'b0;
        s_tlast    = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst/s_tready",    128'(s_tready),    128'(0));
        chk("rst/wr_en",       128'(wr_en),       128'(0));
        chk("rst/wr_data",     wr_data,           128'(0));
        chk("rst/wr_addr_rst", 128'(wr_addr_rst), 128'(0));
        chk("rst/busy",        128'(busy),        128'(0));
        chk("rst/done",        128'(done),        128'(0));
        chk("rst/err",         128'(err),         128'(0));
        @(posedge clk); #1;

        // One group, first batch, back-to-back beats
        beats.delete(); gen(4);
        base = got.size(); c0 = n_clr; d0 = n_done;
        do_start(1'b1, 1);
        @(negedge clk);
        chk("g1/clr_pulse", 128'(wr_addr_rst), 128'(1));
        chk("g1/busy_clr",  128'(busy),        128'(1));
        chk("g1/ready_clr", 128'(s_tready),    128'(0));
        @(posedge clk); #1;
        send("g1", 0, 4, 3, 0);
        tail("g1", 1'b1, 1'b0);
        check_words("g1", base, 2);
        chk("g1/n_clr",  128'(n_clr - c0),  128'(1));
        chk("g1/n_done", 128'(n_done - d0), 128'(1));

        // Two batches: first clears the address, second appends
        beats.delete(); gen(8);
        base = got.size(); c0 = n_clr; d0 = n_done;
        do_start(1'b1, 2);
        send("og_a", 0, 8, 7, 0);
        tail("og_a", 1'b1, 1'b0);
        gen(8);
        do_start(1'b0, 2);
        @(negedge clk);
        chk("og_b/no_clr",     128'(wr_addr_rst), 128'(0));
        chk("og_b/ready_load", 128'(s_tready),    128'(1));
        @(posedge clk); #1;
        send("og_b", 8, 8, 7, 0);
        tail("og_b", 1'b1, 1'b0);
        check_words("og", base, 8);
        chk("og/n_clr",  128'(n_clr - c0),  128'(1));
        chk("og/n_done", 128'(n_done - d0), 128'(2));

        // Three groups with random valid gaps
        beats.delete(); gen(12);
        base = got.size();
        do_start(1'b1, 3);
        send("gap", 0, 12, 11, 50);
        tail("gap", 1'b1, 1'b0);
        check_words("gap", base, 6);

        // Final beat without tlast: error, load still completes
        beats.delete(); gen(4);
        base = got.size();
        do_start(1'b1, 1);
        send("notlast", 0, 4, -1, 0);
        tail("notlast", 1'b1, 1'b1);
        check_words("notlast", base, 2);

        // tlast on even beat 4 of 8: half word dropped; start clears err
        beats.delete(); gen(8);
        base = got.size();
        do_start(1'b1, 2);
        @(negedge clk);
        chk("even_tl/err_cleared", 128'(err), 128'(0));
        @(posedge clk); #1;
        send("even_tl", 0, 5, 4, 0);
        tail("even_tl", 1'b0, 1'b1);
        check_words("even_tl", base, 2);

        // tlast on odd beat 5 of 8: that word is still written
        beats.delete(); gen(8);
        base = got.size();
        do_start(1'b0, 2);
        send("odd_tl", 0, 6, 5, 0);
        tail("odd_tl", 1'b1, 1'b1);
        check_words("odd_tl", base, 3);

        // Out-of-range group counts
        base = got.size(); c0 = n_clr;
        do_start(1'b1, 0);
        tail("ng0", 1'b0, 1'b1);
        do_start(1'b1, MAX_GROUPS + 1);
        tail("ng_over", 1'b0, 1'b1);
        chk("range/no_writes", 128'(got.size() - base), 128'(0));
        chk("range/no_clr",    128'(n_clr - c0),        128'(0));

        // Maximum group count, with a second start ignored while busy
        beats.delete(); gen(4 * MAX_GROUPS);
        base = got.size(); c0 = n_clr; d0 = n_done;
        do_start(1'b1, MAX_GROUPS);
        do_start(1'b1, 5);
        send("max", 0, 4 * MAX_GROUPS, 4 * MAX_GROUPS - 1, 0);
        tail("max", 1'b1, 1'b0);
        check_words("max", base, 2 * MAX_GROUPS);
        chk("max/n_clr",  128'(n_clr - c0),  128'(1));
        chk("max/n_done", 128'(n_done - d0), 128'(1));

        // Reset in the middle of a load, after beat 5
        beats.delete(); gen(8);
        do_start(1'b1, 2);
        send("midrst", 0, 6, -1, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst/busy",     128'(busy),     128'(0));
        chk("midrst/s_tready", 128'(s_tready), 128'(0));
        chk("midrst/wr_en",    128'(wr_en),    128'(0));
        chk("midrst/done",     128'(done),     128'(0));
        chk("midrst/err",      128'(err),      128'(0));
        @(posedge clk); #1;
        beats.delete(); gen(4);
        base = got.size();
        do_start(1'b1, 1);
        send("after_rst", 0, 4, 3, 0);
        tail("after_rst", 1'b1, 1'b0);
        check_words("after_rst", base, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
